// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter and other latch consumers.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } dbnc_state_e;

    localparam int DBNC_SYNC_STAGES_DEF = 2;
    localparam int DBNC_STABLE_DEF      = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int   STAGES    = DBNC_SYNC_STAGES_DEF,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Stage 0 may go metastable; only the last stage is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronises a glitchy latch output, filters it with a consecutive-sample
// counter and emits single-cycle rise/fall pulses.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DBNC_SYNC_STAGES_DEF,
    parameter int   STABLE_CYCLES = DBNC_STABLE_DEF,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    input  logic en_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_edge: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_edge: STABLE_CYCLES must be >= 1");
    end

    logic          s;
    dbnc_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic          q_q;
    logic          rise_q;
    logic          fall_q;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (d_i),
        .q_o    (s)
    );

    // Pulses default low every cycle, so they can only live for the edge q changes on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (en_i && (s != q_q)) begin
                        if (ONE_SHOT) begin
                            q_q    <= s;
                            rise_q <= s;
                            fall_q <= ~s;
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!en_i || (s == q_q)) begin
                        cnt_q   <= '0;
                        state_q <= ST_STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        q_q     <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                        cnt_q   <= '0;
                        state_q <= ST_STABLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_STABLE;
                end
            endcase
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (state_q == ST_PENDING);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge with default parameters.
module tb_debounce_edge;

    logic clk_i;
    logic rst_ni;
    logic d_i;
    logic en_i;
    logic q_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    int checks;
    int errors;

    logic [3:0] obs;
    assign obs = {q_o, rise_o, fall_o, busy_o};

    debounce_edge dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (d_i),
        .en_i   (en_i),
        .q_o    (q_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .busy_o (busy_o)
    );

    initial clk_i = 1'b0;
    always #10 clk_i = ~clk_i;

    // Observation point: 1 ns after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_ni = 1'b0;
        d_i    = 1'b1;
        en_i   = 1'b1;
        exp    = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL reset_hold k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
        rst_ni = 1'b1;
        d_i    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL reset_release k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp;
        d_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL clean_rise k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] exp;
        d_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k < 6, 1'b0, k == 6, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL clean_fall k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        d_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) d_i = 1'b0;
            exp = {1'b0, 1'b0, 1'b0, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL glitch k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] exp;
        en_i = 1'b0;
        d_i  = 1'b1;
        exp  = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL enable_frozen k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
        en_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = {k >= 4, k == 4, 1'b0, (k >= 1 && k <= 3)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL enable_release k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
        d_i = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL enable_return_low {q,rise,fall,busy} got %b want %b", obs, 4'b0000);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] exp;
        d_i = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midcount_busy {q,rise,fall,busy} got %b want %b", obs, 4'b0001);
        end
        #5;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midcount_async_reset {q,rise,fall,busy} got %b want %b", obs, 4'b0000);
        end
        tick();
        tick();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midcount_reset_held {q,rise,fall,busy} got %b want %b", obs, 4'b0000);
        end
        rst_ni = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL midcount_after_release k=%0d {q,rise,fall,busy} got %b want %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_ni = 1'b0;
        d_i    = 1'b0;
        en_i   = 1'b1;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_enable();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
